// File: rtl/edge_filter_core.sv
// 3x3 Sobel edge filter with two line buffers and a fixed 3-stage pipeline.
// Optional feature: define EDGE_FILTER_THRESH_EN to add the iTHRESH binary threshold input.
module edge_filter_core #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 640,
  parameter int CNT_W  = 11
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [CNT_W-1:0]  iX_Cont,
  input  logic [CNT_W-1:0]  iY_Cont,
  input  logic [1:0]        iMODE,
`ifdef EDGE_FILTER_THRESH_EN
  input  logic [DATA_W-1:0] iTHRESH,
`endif
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [CNT_W-1:0]  oX_Cont,
  output logic [CNT_W-1:0]  oY_Cont
);

  localparam int SUM_W = DATA_W + 4;
  localparam int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W:0]   IMG_W_C = (CNT_W + 1)'(IMG_W);
  localparam logic [SUM_W-1:0] SAT     = SUM_W'((1 << DATA_W) - 1);

  // iDVAL is a valid-only qualifier with no backpressure: a pixel is taken on
  // every rising edge where iDVAL is high, iX_Cont is in range and iRST is low.
  logic          accept;
  logic [AW-1:0] addr;
  assign accept = iDVAL && ({1'b0, iX_Cont} < IMG_W_C) && !iRST;
  assign addr   = iX_Cont[AW-1:0];

  logic [DATA_W-1:0] lb1 [IMG_W];  // row y-1
  logic [DATA_W-1:0] lb2 [IMG_W];  // row y-2
  logic [DATA_W-1:0] win [3][3];   // [row][col], 0 = oldest

  logic [1:0]        mode_r;
  logic              v1, msk1;
  logic [1:0]        m1;
  logic [CNT_W-1:0]  x1, y1;

  logic                     v2, msk2;
  logic [1:0]               m2;
  logic [CNT_W-1:0]         x2, y2;
  logic [DATA_W-1:0]        c2;
  logic signed [SUM_W-1:0]  gx2, gy2;

  // Line buffers are never cleared; border masking hides stale rows.
  always_ff @(posedge iCLK) begin
    if (accept) begin
      lb2[addr] <= lb1[addr];
      lb1[addr] <= iDATA;
    end
  end

  // Stage 1: window shift, mode capture, border flag.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      mode_r <= '0;
      v1     <= 1'b0;
      msk1   <= 1'b0;
      m1     <= '0;
      x1     <= '0;
      y1     <= '0;
    end else begin
      v1 <= accept;
      x1 <= iX_Cont;
      y1 <= iY_Cont;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb2[addr];
        win[1][2] <= lb1[addr];
        win[2][2] <= iDATA;
        msk1      <= (iX_Cont < CNT_W'(2)) || (iY_Cont < CNT_W'(2));
        if (iX_Cont == '0 && iY_Cont == '0) begin
          mode_r <= iMODE;
          m1     <= iMODE;
        end else begin
          m1     <= mode_r;
        end
      end
    end
  end

  function automatic logic signed [SUM_W-1:0] ext(input logic [DATA_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  logic signed [SUM_W-1:0] gx_c, gy_c;
  assign gx_c = ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2])
              - ext(win[0][0]) - (ext(win[1][0]) <<< 1) - ext(win[2][0]);
  assign gy_c = ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2])
              - ext(win[0][0]) - (ext(win[0][1]) <<< 1) - ext(win[0][2]);

  // Stage 2: kernel sums.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      v2   <= 1'b0;
      msk2 <= 1'b0;
      m2   <= '0;
      x2   <= '0;
      y2   <= '0;
      c2   <= '0;
      gx2  <= '0;
      gy2  <= '0;
    end else begin
      v2   <= v1;
      msk2 <= msk1;
      m2   <= m1;
      x2   <= x1;
      y2   <= y1;
      c2   <= win[1][1];
      gx2  <= gx_c;
      gy2  <= gy_c;
    end
  end

  logic [SUM_W-1:0]  ax, ay, mag;
  logic [DATA_W-1:0] res, out_c;

  always_comb begin
    ax  = gx2[SUM_W-1] ? SUM_W'(-gx2) : SUM_W'(gx2);
    ay  = gy2[SUM_W-1] ? SUM_W'(-gy2) : SUM_W'(gy2);
    mag = '0;
    case (m2)
      2'd1:    mag = ax;
      2'd2:    mag = ay;
      default: mag = ax + ay;
    endcase
    res = (mag > SAT) ? '1 : mag[DATA_W-1:0];
    out_c = '0;
    if (msk2) begin
      out_c = '0;
    end else if (m2 == 2'd0) begin
      out_c = c2;
    end else begin
`ifdef EDGE_FILTER_THRESH_EN
      out_c = (res >= iTHRESH) ? '1 : '0;
`else
      out_c = res;
`endif
    end
  end

  // Stage 3: registered outputs; oDATA holds between valid pixels.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDATA   <= '0;
      oDVAL   <= 1'b0;
      oX_Cont <= '0;
      oY_Cont <= '0;
    end else begin
      oDVAL   <= v2;
      oX_Cont <= x2;
      oY_Cont <= y2;
      if (v2) oDATA <= out_c;
    end
  end

endmodule

// File: tb/tb_edge_filter_core.sv
// Bench for edge_filter_core: table of frame tests with probe values, reference
// model feeding an expected queue, plus mode-change and mid-frame reset sequences.
module tb_edge_filter_core;

  localparam int DATA_W = 12;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;
  localparam int CNT_W  = 11;
  localparam int QW     = DATA_W + 2 * CNT_W;

  localparam int P_CONST = 0;
  localparam int P_VSTEP = 1;
  localparam int P_HSTEP = 2;
  localparam int P_RAMP  = 3;
  localparam int P_RAND  = 4;

  logic              iCLK = 1'b0;
  logic              iRST;
  logic [DATA_W-1:0] iDATA;
  logic              iDVAL;
  logic [CNT_W-1:0]  iX_Cont, iY_Cont;
  logic [1:0]        iMODE;
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;
  logic [CNT_W-1:0]  oX_Cont, oY_Cont;
`ifdef EDGE_FILTER_THRESH_EN
  logic [DATA_W-1:0] thresh = 12'h040;
  localparam logic [DATA_W-1:0] RAMP_EXP = 12'hFFF;
`else
  localparam logic [DATA_W-1:0] RAMP_EXP = 12'h040;
`endif

  always #5 iCLK = ~iCLK;

  edge_filter_core #(.DATA_W(DATA_W), .IMG_W(IMG_W), .CNT_W(CNT_W)) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iDATA   (iDATA),
    .iDVAL   (iDVAL),
    .iX_Cont (iX_Cont),
    .iY_Cont (iY_Cont),
    .iMODE   (iMODE),
`ifdef EDGE_FILTER_THRESH_EN
    .iTHRESH (thresh),
`endif
    .oDATA   (oDATA),
    .oDVAL   (oDVAL),
    .oX_Cont (oX_Cont),
    .oY_Cont (oY_Cont)
  );

  int                img     [IMG_H][IMG_W];
  int                out_img [IMG_H][IMG_W];
  logic [QW-1:0]     exp_q[$];
  logic [2:0]        hist = '0;
  logic              rst_seen = 1'b0;
  logic              chk_en = 1'b0;
  logic [DATA_W-1:0] last_odata = '0;
  logic [DATA_W-1:0] cur_exp;
  logic [1:0]        frame_mode = '0;
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] model(input int x, input int y, input logic [1:0] m);
    int p [3][3];
    int gx, gy, r;
    if (x < 2 || y < 2) return '0;
    if (m == 2'd0) return DATA_W'(img[y-1][x-1]);
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        p[rr][cc] = img[y-2+rr][x-2+cc];
    gx = p[0][2] + 2*p[1][2] + p[2][2] - p[0][0] - 2*p[1][0] - p[2][0];
    gy = p[2][0] + 2*p[2][1] + p[2][2] - p[0][0] - 2*p[0][1] - p[0][2];
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    r = (m == 2'd1) ? gx : (m == 2'd2) ? gy : gx + gy;
    if (r > 4095) r = 4095;
`ifdef EDGE_FILTER_THRESH_EN
    r = (r >= int'(thresh)) ? 4095 : 0;
`endif
    return DATA_W'(r);
  endfunction

  // Scoreboard input side: record accepted pixels and reset events.
  always @(posedge iCLK) begin
    rst_seen <= iRST;
    if (iRST) begin
      hist <= '0;
      exp_q.delete();
    end else begin
      hist <= {hist[1:0], (iDVAL && iX_Cont < IMG_W)};
      if (iDVAL && iX_Cont < IMG_W) exp_q.push_back({cur_exp, iX_Cont, iY_Cont});
    end
  end

  // Scoreboard output side, sampled away from the active edge.
  always @(negedge iCLK) begin
    logic [QW-1:0]     e;
    logic [DATA_W-1:0] ed;
    logic [CNT_W-1:0]  ex, ey;
    if (chk_en) begin
      if (rst_seen) begin
        chk("rst_dval", 32'(oDVAL), 32'd0);
        chk("rst_data", 32'(oDATA), 32'd0);
        chk("rst_xy", 32'({oX_Cont, oY_Cont}), 32'd0);
        last_odata = '0;
      end else begin
        chk("dval_delay", 32'(oDVAL), 32'(hist[2]));
        if (oDVAL) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'(oDVAL), 32'd0);
          end else begin
            e = exp_q.pop_front();
            {ed, ex, ey} = e;
            chk("data", 32'(oDATA), 32'(ed));
            chk("xcoord", 32'(oX_Cont), 32'(ex));
            chk("ycoord", 32'(oY_Cont), 32'(ey));
            if (ex < IMG_W && ey < IMG_H) out_img[ey][ex] = int'(oDATA);
          end
          last_odata = oDATA;
        end else begin
          chk("hold", 32'(oDATA), 32'(last_odata));
        end
      end
    end
  end

  task automatic drive(input logic dv, input int x, input int y, input logic [1:0] m);
    iDVAL   = dv;
    iX_Cont = CNT_W'(x);
    iY_Cont = CNT_W'(y);
    iMODE   = m;
    if (dv && x == 0 && y == 0) frame_mode = m;
    iDATA   = (x < IMG_W && y < IMG_H) ? DATA_W'(img[y][x]) : DATA_W'($urandom_range(0, 4095));
    cur_exp = (x < IMG_W && y < IMG_H) ? model(x, y, frame_mode) : '0;
    @(posedge iCLK);
    #1;
  endtask

  task automatic fill(input int pat);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) begin
        case (pat)
          P_CONST: img[y][x] = 'h800;
          P_VSTEP: img[y][x] = (x >= 4) ? 'hFFF : 0;
          P_HSTEP: img[y][x] = (y >= 3) ? 'hFFF : 0;
          P_RAMP:  img[y][x] = x * 8;
          default: img[y][x] = int'($urandom_range(0, 4095));
        endcase
        out_img[y][x] = -1;
      end
  endtask

  task automatic drive_frame(input int pat, input logic [1:0] ma, input logic [1:0] mb,
                             input int change_idx, input logic gaps);
    fill(pat);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) begin
        if (gaps)
          while ($urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 3) == 0) drive(1'b1, IMG_W + int'($urandom_range(0, 3)), y, ma);
            else                           drive(1'b0, x, y, ma);
          end
        drive(1'b1, x, y, (y * IMG_W + x >= change_idx) ? mb : ma);
      end
    repeat (6) drive(1'b0, 0, 0, ma);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [1:0]        mode;
    int                pat;
    logic              gaps;
    int                px;
    int                py;
    logic [DATA_W-1:0] pexp;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'd3, P_CONST, 1'b0, 4, 3, 12'h000};
    vecs[1]  = '{2'd3, P_CONST, 1'b1, 6, 5, 12'h000};
    vecs[2]  = '{2'd1, P_VSTEP, 1'b0, 4, 3, 12'hFFF};
    vecs[3]  = '{2'd1, P_VSTEP, 1'b1, 5, 3, 12'hFFF};
    vecs[4]  = '{2'd1, P_VSTEP, 1'b0, 6, 3, 12'h000};
    vecs[5]  = '{2'd2, P_VSTEP, 1'b0, 4, 3, 12'h000};
    vecs[6]  = '{2'd0, P_VSTEP, 1'b0, 5, 3, 12'hFFF};
    vecs[7]  = '{2'd0, P_VSTEP, 1'b1, 4, 3, 12'h000};
    vecs[8]  = '{2'd0, P_VSTEP, 1'b0, 5, 1, 12'h000};
    vecs[9]  = '{2'd2, P_HSTEP, 1'b0, 3, 3, 12'hFFF};
    vecs[10] = '{2'd1, P_HSTEP, 1'b1, 3, 3, 12'h000};
    vecs[11] = '{2'd3, P_RAMP,  1'b0, 3, 3, RAMP_EXP};
    vecs[12] = '{2'd0, P_CONST, 1'b0, 2, 2, 12'h800};
    vecs[13] = '{2'd0, P_CONST, 1'b1, 1, 4, 12'h000};
    vecs[14] = '{2'd1, P_RAND,  1'b1, -1, -1, 12'h000};

    // clock/reset
    iRST = 1'b1; iDVAL = 1'b0; iDATA = '0; iX_Cont = '0; iY_Cont = '0; iMODE = '0;
    cur_exp = '0;
    repeat (2) @(posedge iCLK);
    #1;
    chk_en = 1'b1;
    @(posedge iCLK);
    #1;
    iRST = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive_frame(vecs[i].pat, vecs[i].mode, vecs[i].mode, IMG_W * IMG_H, vecs[i].gaps);
      if (vecs[i].px >= 0)
        chk($sformatf("probe%0d", i), 32'(out_img[vecs[i].py][vecs[i].px]), 32'(vecs[i].pexp));
    end

    // Mode change at (5,3) must not take effect until the next frame.
    drive_frame(P_VSTEP, 2'd1, 2'd2, 3 * IMG_W + 5, 1'b0);
    chk("mode_kept_a", 32'(out_img[3][4]), 32'hFFF);
    chk("mode_kept_b", 32'(out_img[4][5]), 32'hFFF);
    drive_frame(P_VSTEP, 2'd2, 2'd2, IMG_W * IMG_H, 1'b0);
    chk("mode_next", 32'(out_img[3][4]), 32'h000);

    // Mid-frame reset at (4,4), then a fresh frame.
    fill(P_VSTEP);
    for (int p = 0; p < 4 * IMG_W + 4; p++) drive(1'b1, p % IMG_W, p / IMG_W, 2'd1);
    iRST = 1'b1;
    drive(1'b1, 4, 4, 2'd1);
    drive(1'b1, 5, 4, 2'd1);
    iRST = 1'b0;
    fork
      drive_frame(P_CONST, 2'd0, 2'd0, IMG_W * IMG_H, 1'b0);
      begin
        repeat (3) begin
          @(negedge iCLK);
          chk("post_rst_dval", 32'(oDVAL), 32'd0);
        end
      end
    join
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < IMG_W; x++)
        chk("post_rst_row01", 32'(out_img[y][x]), 32'd0);
    chk("post_rst_center", 32'(out_img[2][2]), 32'h800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
